// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: extension-op codes, fetch state
// encoding and the default reset PC.
package fetch_unit_pkg;

  localparam logic [2:0] EXT_UI5    = 3'b000;
  localparam logic [2:0] EXT_SI12   = 3'b001;
  localparam logic [2:0] EXT_UI12   = 3'b010;
  localparam logic [2:0] EXT_SI20   = 3'b011;
  localparam logic [2:0] EXT_OFFS16 = 3'b100;
  localparam logic [2:0] EXT_OFFS26 = 3'b101;
  localparam logic [2:0] EXT_NONE   = 3'b111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_ext_op_decode.sv
// Combinational pre-decode of the immediate-extension op from a raw
// LoongArch32 instruction word; the earliest matching opcode class wins.
module ext_op_decode
  import fetch_unit_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [2:0]  o_ext_op
);

  logic [16:0] w_op17;
  logic [9:0]  w_op10;
  logic [6:0]  w_op7;
  logic [5:0]  w_op6;
  logic        w_unused_low;

  assign w_op17       = i_inst[31:15];
  assign w_op10       = i_inst[31:22];
  assign w_op7        = i_inst[31:25];
  assign w_op6        = i_inst[31:26];
  assign w_unused_low = ^i_inst[14:0];

  always_comb begin
    o_ext_op = EXT_NONE;
    if (w_op17 inside {17'h00081, 17'h00089, 17'h00091})
      o_ext_op = EXT_UI5;
    else if (w_op10 inside {10'h008, 10'h009, 10'h00A, 10'h0A0, 10'h0A1, 10'h0A2,
                            10'h0A4, 10'h0A5, 10'h0A6, 10'h0A8, 10'h0A9})
      o_ext_op = EXT_SI12;
    else if (w_op10 inside {10'h00D, 10'h00E, 10'h00F})
      o_ext_op = EXT_UI12;
    else if (w_op7 inside {7'h0A, 7'h0E})
      o_ext_op = EXT_SI20;
    else if (w_op6 inside {6'h13, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B})
      o_ext_op = EXT_OFFS16;
    else if (w_op6 inside {6'h14, 6'h15})
      o_ext_op = EXT_OFFS26;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding word read to
// instruction memory, redirect handling and a one-entry output holding stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [25:0] out_imm_src,
  output logic [2:0]  out_ext_op
);

  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_out_pc;
  logic [31:0]  r_out_inst;
  logic [2:0]   r_out_ext_op;
  logic [2:0]   w_ext_op;
  logic [31:0]  w_redirect_pc;
  logic         w_capture;

  ext_op_decode u_ext_op_decode (
    .i_inst   (imem_rdata),
    .o_ext_op (w_ext_op)
  );

  assign w_redirect_pc = redirect_pc & ~32'h3;
  assign w_capture     = (r_state == ST_WAIT) && imem_rvalid && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_REQ;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_REQ: begin
        // A grant taken alongside a redirect still owes us a response.
        if (imem_gnt) w_next_state = redirect_valid ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid)         w_next_state = redirect_valid ? ST_REQ : ST_HOLD;
        else if (redirect_valid) w_next_state = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid) w_next_state = ST_REQ;
      end
      ST_HOLD: begin
        if (redirect_valid || out_ready) w_next_state = ST_REQ;
      end
      default: w_next_state = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req  = (r_state == ST_REQ) && !rst;
    out_valid = (r_state == ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= w_redirect_pc;
    else if (w_capture)      r_pc <= r_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_pc     <= '0;
      r_out_inst   <= '0;
      r_out_ext_op <= '0;
    end else if (w_capture) begin
      r_out_pc     <= r_pc;
      r_out_inst   <= imem_rdata;
      r_out_ext_op <= w_ext_op;
    end
  end

  assign imem_addr   = r_pc;
  assign out_pc      = r_out_pc;
  assign out_inst    = r_out_inst;
  assign out_imm_src = r_out_inst[25:0];
  assign out_ext_op  = r_out_ext_op;

endmodule
